// File: rtl/eddsa_itf_master.sv
// Host-side initiator for the EdDSA25519 register interface: streams a job's input
// words into the core, runs it under a timeout, then streams the result words back out.
module eddsa_itf_master #(
  parameter int          WIDTH   = 64,
  parameter int          N_IN    = 34,
  parameter int          N_OUT   = 9,
  parameter logic [23:0] TIMEOUT = 24'd16_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [3:0]       control,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] data_out,
  input  logic             end_op
);

  localparam int IW = $clog2((N_IN > N_OUT) ? N_IN : N_OUT);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 24'd1);

  // control = {read, load, rst_itf, rst}
  localparam logic [3:0] C_HOLD = 4'b0011;
  localparam logic [3:0] C_IDLE = 4'b0001;
  localparam logic [3:0] C_LOAD = 4'b0101;
  localparam logic [3:0] C_RUN  = 4'b0000;
  localparam logic [3:0] C_READ = 4'b1000;

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD, RUN, RD_REQ, RD_CAP, RD_OUT, FIN
  } state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx, idx_d, idx_inc;
  logic [TW-1:0]    timer, timer_d;
  logic [3:0]       control_d;
  logic [WIDTH-1:0] address_d, data_in_d, out_data_d;
  logic             in_ready_d, out_valid_d, busy_d, done_d, timeout_err_d;

  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    timer_d       = timer;
    control_d     = control;
    address_d     = address;
    data_in_d     = data_in;
    out_data_d    = out_data;
    in_ready_d    = in_ready;
    out_valid_d   = out_valid;
    busy_d        = busy;
    done_d        = 1'b0;
    timeout_err_d = timeout_err;
    unique case (state)
      IDLE: begin
        control_d = C_IDLE;
        if (start) begin
          state_d       = CLR;
          control_d     = C_HOLD;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          idx_d         = '0;
        end
      end
      CLR: begin
        state_d    = LOAD;
        control_d  = C_IDLE;
        in_ready_d = 1'b1;
      end
      LOAD: begin
        // core stays in reset for the whole load; load only pulses with a word
        control_d = C_IDLE;
        if (in_valid && in_ready) begin
          control_d = C_LOAD;
          address_d = WIDTH'(idx);
          data_in_d = in_data;
          idx_d     = idx_inc;
          if (idx == IW'(N_IN - 1)) begin
            state_d    = RUN;
            in_ready_d = 1'b0;
            idx_d      = '0;
            timer_d    = '0;
          end
        end
      end
      RUN: begin
        control_d = C_RUN;
        // first RUN cycle still shows the last load, so end_op is not trusted yet
        if (end_op && timer != '0) begin
          state_d   = RD_REQ;
          control_d = C_READ;
          address_d = WIDTH'(idx);
        end else if (timer == T_LAST) begin
          state_d       = FIN;
          control_d     = C_IDLE;
          timeout_err_d = 1'b1;
          done_d        = 1'b1;
          busy_d        = 1'b0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      RD_REQ: state_d = RD_CAP;
      RD_CAP: begin
        state_d     = RD_OUT;
        control_d   = C_RUN;
        out_data_d  = data_out;
        out_valid_d = 1'b1;
      end
      RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          idx_d       = idx_inc;
          if (idx == IW'(N_OUT - 1)) begin
            state_d   = FIN;
            control_d = C_IDLE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end else begin
            state_d   = RD_REQ;
            control_d = C_READ;
            address_d = WIDTH'(idx_inc);
          end
        end
      end
      FIN: begin
        state_d   = IDLE;
        control_d = C_IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      timer       <= '0;
      control     <= C_HOLD;
      address     <= '0;
      data_in     <= '0;
      out_data    <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      timer       <= timer_d;
      control     <= control_d;
      address     <= address_d;
      data_in     <= data_in_d;
      out_data    <= out_data_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      busy        <= busy_d;
      done        <= done_d;
      timeout_err <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_eddsa_itf_master.sv
// Bench for eddsa_itf_master: an interface/core responder plus a negedge scoreboard
// tracking loads, reads and output words, driven by directed job scenarios.
module tb_eddsa_itf_master;
  localparam int N_IN = 34;
  localparam int N_OUT = 9;
  localparam logic [63:0] BASE = 64'hA5A5_0000_0000_0000;

  logic clk, rst, start, in_valid, in_ready, out_valid, out_ready;
  logic busy, done, timeout_err, end_op;
  logic [63:0] in_data, out_data, address, data_in, data_out;
  logic [3:0] control;

  eddsa_itf_master #(.WIDTH(64), .N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .control(control), .address(address), .data_in(data_in),
    .data_out(data_out), .end_op(end_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int tcyc = 0;
  int job = 0;
  bit exp_to = 1'b0, eop_force = 1'b0;
  int eop_dly = 50;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] in_word(input int j, input int k);
    return {32'hBEEF_0000 + 32'(j), 32'h1000_0000 + 32'(k)};
  endfunction

  always @(posedge clk) tcyc <= tcyc + 1;

  // interface + core responder
  logic [63:0] in_regs [64];
  int ecnt = 0;
  always @(posedge clk) begin
    if (control[1]) begin
      for (int k = 0; k < 64; k++) in_regs[k] <= '0;
    end else if (control[2]) begin
      in_regs[address[5:0]] <= data_in;
    end
    data_out <= control[3] ? BASE + address : 64'h0;
    ecnt <= control[0] ? 0 : ecnt + 1;
  end
  assign end_op = eop_force | (!control[0] && ecnt >= eop_dly);

  // scoreboard, sampled mid-cycle
  int s_cyc, run_entry, first_rd, done_cyc, ld_cnt, out_cnt, rd_cyc, ov_cyc;
  int done_total = 0;
  logic [63:0] first_out, last_out, prev_od;
  bit prev_ov = 1'b0, prev_or = 1'b0;

  always @(negedge clk) begin
    if (start && !busy && !rst) begin
      s_cyc = tcyc; run_entry = -1; first_rd = -1; done_cyc = -1;
      ld_cnt = 0; out_cnt = 0; rd_cyc = 0; ov_cyc = 0;
    end
    if (control[2]) begin
      chk("ld_addr", address, 64'(ld_cnt));
      chk("ld_data", data_in, in_word(job, ld_cnt));
      chk("ld_core_rst", 64'(control[0]), 64'd1);
      if (ld_cnt == N_IN - 1) run_entry = tcyc;
      ld_cnt++;
    end
    if (control[3]) begin
      chk("rd_addr", address, 64'(out_cnt));
      chk("rd_core_run", 64'(control[0]), 64'd0);
      if (first_rd < 0) first_rd = tcyc;
      rd_cyc++;
    end
    if (out_valid) ov_cyc++;
    if (prev_ov && !prev_or && out_valid) chk("stall_hold", out_data, prev_od);
    if (out_valid && out_ready) begin
      chk("out_data", out_data, BASE + 64'(out_cnt));
      if (out_cnt == 0) first_out = out_data;
      last_out = out_data;
      out_cnt++;
    end
    if (done) begin
      done_total++;
      done_cyc = tcyc;
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_timeout_err", 64'(timeout_err), 64'(exp_to));
      chk("done_loads", 64'(ld_cnt), 64'(N_IN));
      chk("done_outs", 64'(out_cnt), exp_to ? 64'd0 : 64'(N_OUT));
    end
    prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_rst(input string t);
    chk({t, "_control"}, 64'(control), 64'h3);
    chk({t, "_address"}, address, 64'h0);
    chk({t, "_data_in"}, data_in, 64'h0);
    chk({t, "_out_data"}, out_data, 64'h0);
    chk({t, "_flags"}, 64'({in_ready, out_valid, busy, done, timeout_err}), 64'h0);
  endtask

  task automatic do_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic feed(input bit toggle, input int n);
    int sent = 0, c = 0;
    bit hs;
    while (sent < n && c < 500) begin
      in_valid = toggle ? c[0] : 1'b1;
      in_data = in_word(job, sent);
      hs = in_valid && in_ready;
      step(); c++;
      if (hs) sent++;
    end
    in_valid = 1'b0;
    chk("feed_sent", 64'(sent), 64'(n));
  endtask

  task automatic drain(input int stall);
    int vc = 0, n = 0;
    bit hs;
    out_ready = (stall == 0);
    while (!done && n < 3000) begin
      hs = out_valid && out_ready;
      step(); n++;
      if (hs || !out_valid) vc = 0; else vc++;
      out_ready = (stall == 0) || (vc >= stall);
    end
    chk("done_seen", 64'(done), 64'd1);
    step();
    chk("done_single_cycle", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic chk_regs(input string t);
    for (int k = 0; k < N_IN; k++) chk(t, in_regs[k], in_word(job, k));
  endtask

  int td, hsn, nn;
  bit hsx;

  initial begin
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) step();
    chk_rst("reset");
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle_control", 64'(control), 64'h1);
    chk("idle_busy0", 64'(busy), 64'd0);

    // full job, end_op after 50 core cycles
    job = 1; exp_to = 1'b0;
    do_start();
    chk("clr_control", 64'(control), 64'h3);
    chk("clr_busy", 64'(busy), 64'd1);
    chk("clr_in_ready", 64'(in_ready), 64'd0);
    feed(1'b0, N_IN);
    drain(0);
    chk("a_run_entry", 64'(run_entry - s_cyc), 64'd36);
    chk("a_first_read", 64'(first_rd - run_entry), 64'd52);
    chk("a_done_time", 64'(done_cyc - run_entry), 64'd79);
    chk("a_read_cycles", 64'(rd_cyc), 64'd18);
    chk("a_first_word", first_out, 64'hA5A5_0000_0000_0000);
    chk("a_last_word", last_out, 64'hA5A5_0000_0000_0008);
    chk("a_timeout_err", 64'(timeout_err), 64'd0);
    chk_regs("a_in_regs");

    // toggled in_valid, stalled out_ready, stray start while busy
    job = 2;
    do_start();
    feed(1'b1, N_IN);
    do_start();
    drain(5);
    chk("b_read_cycles", 64'(rd_cyc), 64'd18);
    chk("b_outs", 64'(out_cnt), 64'(N_OUT));
    chk_regs("b_in_regs");

    // end_op never comes
    job = 3; exp_to = 1'b1; eop_dly = 1000;
    do_start();
    feed(1'b0, N_IN);
    drain(0);
    chk("c_done_time", 64'(done_cyc - run_entry), 64'd100);
    chk("c_no_read", 64'(first_rd), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("c_no_out_valid", 64'(ov_cyc), 64'd0);
    chk("c_timeout_err", 64'(timeout_err), 64'd1);
    eop_dly = 50;

    // stale end_op held high, minimum-length job
    job = 4; exp_to = 1'b0; eop_force = 1'b1;
    do_start();
    chk("d_timeout_err_cleared", 64'(timeout_err), 64'd0);
    feed(1'b0, N_IN);
    in_valid = 1'b1;
    drain(0);
    in_valid = 1'b0;
    chk("d_first_read", 64'(first_rd - run_entry), 64'd2);
    chk("d_job_length", 64'(done_cyc - s_cyc), 64'd65);
    eop_force = 1'b0;

    // reset during LOAD at word 10
    job = 5; td = done_total;
    do_start();
    feed(1'b0, 10);
    rst = 1'b1; step(); rst = 1'b0;
    chk_rst("abort_load");
    repeat (20) step();
    chk("abort_load_no_done", 64'(done_total), 64'(td));

    // reset during RD_OUT at word 4
    job = 6;
    do_start();
    feed(1'b0, N_IN);
    hsn = 0; nn = 0; out_ready = 1'b1;
    while (!(out_valid && hsn == 4) && nn < 2000) begin
      hsx = out_valid && out_ready;
      step(); nn++;
      if (hsx) hsn++;
    end
    out_ready = 1'b0;
    chk("abort_rd_word", 64'(hsn), 64'd4);
    rst = 1'b1; step(); rst = 1'b0;
    chk_rst("abort_rd");
    repeat (20) step();
    chk("abort_rd_no_done", 64'(done_total), 64'(td));

    // clean job after aborts
    job = 7;
    do_start();
    feed(1'b0, N_IN);
    drain(0);
    chk("g_read_cycles", 64'(rd_cyc), 64'd18);
    chk("g_done_count", 64'(done_total), 64'(td + 1));
    chk_regs("g_in_regs");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eddsa_itf_master.md
# eddsa_itf_master

Hardware initiator for the EdDSA25519 register-mapped interface, i.e. the host-side end of its `{read, load, rst_itf, rst}` control / address / data protocol. It accepts a job as a stream of 64-bit input words, writes them into the interface's input register file, holds and releases the core reset, and waits for `end_op` under a timeout. It then reads back the output register file and streams those words out. It replaces software register polling when EdDSA is driven from another hardware block, for example a DMA or a test sequencer.

## Interface
- WIDTH, 64, data/address word width.
- N_IN, 34, input words written per job (addresses 0..N_IN-1).
- N_OUT, 9, output words read per job (addresses 0..N_OUT-1).
- TIMEOUT, 24'd16_000_000, maximum cycles waited for `end_op`.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job request; ignored unless `busy`=0.
- in_valid / in_ready  in/out  1/1  input-word handshake; a transfer occurs when both are 1.
- in_data  in  WIDTH  input word; the k-th accepted word goes to address k.
- out_valid / out_ready  out/in  1/1  output-word handshake.
- out_data  out  WIDTH  output word; the k-th word is from address k.
- busy  out  1  high from the accepted `start` until `done`.
- done  out  1  one-cycle pulse at job end.
- timeout_err  out  1  set with `done` if `end_op` never came; cleared on next `start`.
- control  out  4  to interface: {read, load, rst_itf, rst}.
- address  out  WIDTH  to interface.
- data_in  out  WIDTH  to interface.
- data_out  in  WIDTH  from interface; valid the cycle after `read`=1 with a stable address.
- end_op  in  1  from interface; core finished.

## Operation
- All outputs are registered.
- Reset values: `control`=4'b0011 (core and interface held in reset). `address`, `data_in` and `out_data` are 0. `in_ready`, `out_valid`, `busy`, `done` and `timeout_err` are 0. State is IDLE.
- IDLE: `control`=4'b0001. On `start`, go to CLR, set `busy`, clear `timeout_err`, and clear `idx`.
- CLR (1 cycle): `control`=4'b0011, which clears the input register file. Go to LOAD.
- LOAD: `in_ready`=1 and core `rst`=1 throughout. On each in_valid & in_ready: `address`=idx, `data_in`=in_data, `load`=1 for that cycle, then idx++. Cycles with no transfer drive `load`=0. After word N_IN-1, drop `in_ready` and go to RUN with idx=0 and the timer at 0.
- RUN: `control`=4'b0000, so the core runs.
  - `end_op` is ignored in the first RUN cycle.
  - From the second cycle on, `end_op`=1 moves the block to RD_REQ.
  - The timer increments every cycle. When it reaches TIMEOUT-1 without `end_op`: set `timeout_err`, set `control`=4'b0001, and go to FIN.
- RD_REQ (1 cycle): `address`=idx, `read`=1. Go to RD_CAP.
- RD_CAP: keep `read`=1 and the same address. Latch `data_out` into `out_data`, set `out_valid`, and go to RD_OUT.
- RD_OUT: hold `out_data`/`out_valid` until `out_ready`. On the handshake, clear `out_valid` and idx++. If idx was N_OUT-1, go to FIN; otherwise go to RD_REQ.
- FIN (1 cycle): `done`=1, `busy`=0, `control`=4'b0001. Go to IDLE.
- `idx` is a clog2(max(N_IN,N_OUT))-bit counter. The timer is a clog2(TIMEOUT)-bit counter with no wrap (the saturating compare ends RUN).
- `start` while `busy`=1 is ignored and not queued.
- `rst` asserted in any state aborts the job with no `done` pulse; all outputs take their reset values the next cycle.
- `in_valid` outside LOAD is ignored; `in_ready`=0 there.

## Timing
- `start` to CLR: 1 cycle.
- Minimum job length: 1 (CLR) + N_IN (LOAD, `in_valid` held 1) + 2 (RUN minimum) + 3·N_OUT (with `out_ready` held 1) + 1 (FIN).
- `load` is asserted in the same cycle `address` and `data_in` present the word, so the interface samples them on the following edge.
- Core `rst` stays asserted continuously from CLR to the end of LOAD, so the core never sees a partial input set. A stale `end_op` from a previous job is cleared by that reset.
- The read address is stable for 2 cycles (RD_REQ and RD_CAP). `data_out` is sampled at the end of RD_CAP.
- `done` is high for exactly 1 cycle. `busy` falls in the same cycle `done` rises.

## Test plan
- Reset with `start`=1: `control`=4'b0011 and all flags 0. After release `control`=4'b0001 and `start` is accepted 1 cycle later.
- Full job, model responder returning data_out = 64'hA5A5_0000_0000_0000 + address, `end_op` after 50 RUN cycles: the responder captures words 0..33 at addresses 0..33. out_data reads A5A5…0000 through A5A5…0008, then `done` pulses once with `timeout_err`=0.
- `in_valid` toggled every other cycle and `out_ready` stalled 5 cycles per word: no word is lost or duplicated, `load` pulses exactly 34 times, and `out_data` is stable while stalled.
- `end_op` never asserts, TIMEOUT=100: `done` comes exactly 100 RUN cycles after RUN entry with `timeout_err`=1, no `read` is issued, and no `out_valid`.
- `end_op` held high from a prior job at RUN entry: it is ignored during LOAD/CLR (core reset), and the first-cycle guard prevents a premature RD_REQ.
- `rst` pulsed during LOAD at word 10 and again in RD_OUT at word 4: no `done`, reset values in the next cycle. A new `start` then runs a clean full job starting at address 0.
